// File: rtl/sdram_pattern_checker_if.sv
// Request/response bus between the pattern checker and the SDRAM controller user port.
// The checker drives the request fields; the controller returns the ack and the read data.
interface sdram_pattern_checker_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              cmd_req;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_req, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ack, rd_valid, rd_data
  );

  modport slave (
    input  cmd_req, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ack, rd_valid, rd_data
  );
endinterface

// File: rtl/sdram_pattern_checker.sv
// SDRAM self-test: writes an index-derived pattern over a window, reads it back and compares.
// Clean passes repeat with inverted polarity; a mismatch or read timeout latches a terminal error.
module sdram_pattern_checker #(
  parameter int                 ADDR_W     = 24,
  parameter int                 DATA_W     = 16,
  parameter int                 NUM_WORDS  = 256,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [DATA_W-1:0]  SEED       = DATA_W'(16'hA5A5),
  parameter int                 TIMEOUT    = 1024,
  parameter int                 BLINK_DIV  = 25_000_000
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 init_done,
  sdram_pattern_checker_if.master bus,
  output logic                 error,
  output logic                 timeout,
  output logic                 done,
  output logic [7:0]           pass_cnt,
  output logic [ADDR_W-1:0]    err_addr,
  output logic                 led_0,
  output logic                 led_1
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int BL_W  = $clog2(BLINK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, PASS, FAIL} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              polarity_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [BL_W-1:0]   blink_cnt_reg;
  logic [IDX_W-1:0]  idx_next;

  function automatic logic [DATA_W-1:0] pattern(input logic [IDX_W-1:0] i, input logic pol);
    return DATA_W'(i) ^ SEED ^ {DATA_W{pol}};
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return START_ADDR + ADDR_W'(i);
  endfunction

  assign idx_next = idx_reg + IDX_W'(1);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      polarity_reg  <= 1'b0;
      to_cnt_reg    <= '0;
      bus.cmd_req   <= 1'b0;
      bus.cmd_we    <= 1'b0;
      bus.cmd_addr  <= '0;
      bus.cmd_wdata <= '0;
      error         <= 1'b0;
      timeout       <= 1'b0;
      done          <= 1'b0;
      pass_cnt      <= '0;
      err_addr      <= '0;
      led_1         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (init_done) begin
            state_reg     <= WR;
            bus.cmd_req   <= 1'b1;
            bus.cmd_we    <= 1'b1;
            bus.cmd_addr  <= addr_of('0);
            bus.cmd_wdata <= pattern('0, polarity_reg);
          end
        end

        // Writes stream back-to-back: the next word is presented in the ack cycle itself.
        WR: begin
          if (bus.cmd_ack) begin
            if (idx_reg == LAST_IDX) begin
              idx_reg     <= '0;
              bus.cmd_req <= 1'b0;
              state_reg   <= RD_REQ;
            end else begin
              idx_reg       <= idx_next;
              bus.cmd_addr  <= addr_of(idx_next);
              bus.cmd_wdata <= pattern(idx_next, polarity_reg);
            end
          end
        end

        // Request is raised one cycle after entry so an ack arriving with cmd_req low is ignored.
        RD_REQ: begin
          if (!bus.cmd_req) begin
            bus.cmd_req  <= 1'b1;
            bus.cmd_we   <= 1'b0;
            bus.cmd_addr <= addr_of(idx_reg);
          end else if (bus.cmd_ack) begin
            bus.cmd_req <= 1'b0;
            to_cnt_reg  <= '0;
            state_reg   <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (bus.rd_valid) begin
            if (bus.rd_data == pattern(idx_reg, polarity_reg)) begin
              if (idx_reg == LAST_IDX) begin
                state_reg <= PASS;
              end else begin
                idx_reg   <= idx_next;
                state_reg <= RD_REQ;
              end
            end else begin
              state_reg <= FAIL;
              error     <= 1'b1;
              led_1     <= 1'b1;
              err_addr  <= addr_of(idx_reg);
            end
          end else if (to_cnt_reg == TO_LAST) begin
            state_reg <= FAIL;
            error     <= 1'b1;
            led_1     <= 1'b1;
            timeout   <= 1'b1;
            err_addr  <= addr_of(idx_reg);
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end

        PASS: begin
          pass_cnt      <= pass_cnt + 8'd1;
          done          <= 1'b1;
          polarity_reg  <= ~polarity_reg;
          idx_reg       <= '0;
          state_reg     <= WR;
          bus.cmd_req   <= 1'b1;
          bus.cmd_we    <= 1'b1;
          bus.cmd_addr  <= addr_of('0);
          bus.cmd_wdata <= pattern('0, ~polarity_reg);
        end

        FAIL: begin
          bus.cmd_req <= 1'b0;
        end

        default: begin
          state_reg   <= IDLE;
          bus.cmd_req <= 1'b0;
        end
      endcase
    end
  end

  // Heartbeat freezes once the test has failed so the LED level itself is a hint.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      led_0         <= 1'b0;
    end else if (state_reg != FAIL) begin
      if (blink_cnt_reg == BL_LAST) begin
        blink_cnt_reg <= '0;
        led_0         <= ~led_0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Directed bench for sdram_pattern_checker: behavioural SDRAM responder plus table of expected writes.
module tb_sdram_pattern_checker;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_done = 1'b0;
  logic              error, timeout, done, led_0, led_1;
  logic [7:0]        pass_cnt;
  logic [ADDR_W-1:0] err_addr;

  sdram_pattern_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_pattern_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(4), .START_ADDR(24'd0),
    .SEED(16'hA5A5), .TIMEOUT(16), .BLINK_DIV(8)
  ) dut (
    .clk_50m(clk), .rst(rst), .init_done(init_done), .bus(bus),
    .error(error), .timeout(timeout), .done(done), .pass_cnt(pass_cnt),
    .err_addr(err_addr), .led_0(led_0), .led_1(led_1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder configuration and logs
  int               ack_delay = 0;
  bit               corrupt_en = 0;
  bit               withhold_en = 0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [ADDR_W-1:0] withhold_addr = '0;
  logic [DATA_W-1:0] mem [16];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int               rd_ack_cnt = 0;
  int               last_rd_ack_edge = 0;

  initial begin
    int wait_cnt;
    int rd_cnt;
    logic [DATA_W-1:0] rd_pend;
    logic [40:0] held;
    wait_cnt = 0;
    rd_cnt = 0;
    rd_pend = '0;
    held = '0;
    bus.cmd_ack = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.cmd_ack = 1'b0;
      bus.rd_valid = 1'b0;
      if (rst) begin
        wait_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            bus.rd_valid = 1'b1;
            bus.rd_data = rd_pend;
          end
        end
        if (bus.cmd_req) begin
          if (wait_cnt == 0) held = {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
          if (wait_cnt == ack_delay) begin
            if (ack_delay > 0)
              check("req_fields_stable", 64'({bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}), 64'(held));
            bus.cmd_ack = 1'b1;
            wait_cnt = 0;
            if (bus.cmd_we) begin
              mem[bus.cmd_addr[3:0]] = bus.cmd_wdata;
              wr_addr_q.push_back(bus.cmd_addr);
              wr_data_q.push_back(bus.cmd_wdata);
              $display("%0t wr addr=%0h data=%h", $time, bus.cmd_addr, bus.cmd_wdata);
            end else begin
              rd_addr_q.push_back(bus.cmd_addr);
              rd_ack_cnt++;
              last_rd_ack_edge = cyc + 1;
              $display("%0t rd addr=%0h", $time, bus.cmd_addr);
              if (!(withhold_en && bus.cmd_addr == withhold_addr)) begin
                rd_cnt = 3;
                rd_pend = (corrupt_en && bus.cmd_addr == corrupt_addr) ? '0 : mem[bus.cmd_addr[3:0]];
              end
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_vec_t;

  wr_vec_t vec [8];

  task automatic apply_reset();
    rst = 1'b1;
    init_done = 1'b0;
    ack_delay = 0;
    corrupt_en = 0;
    withhold_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    rd_ack_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_req"}, 64'(bus.cmd_req), 64'd0);
    check({tag, "_cmd_we"}, 64'(bus.cmd_we), 64'd0);
    check({tag, "_cmd_addr"}, 64'(bus.cmd_addr), 64'd0);
    check({tag, "_cmd_wdata"}, 64'(bus.cmd_wdata), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'd0);
    check({tag, "_err_addr"}, 64'(err_addr), 64'd0);
    check({tag, "_led_0"}, 64'(led_0), 64'd0);
    check({tag, "_led_1"}, 64'(led_1), 64'd0);
  endtask

  task automatic check_writes(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (i < wr_addr_q.size()) begin
        check({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(vec[i].addr));
        check({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(vec[i].data));
      end else begin
        check({tag, "_wr_missing"}, 64'(wr_addr_q.size()), 64'(i + 1));
      end
    end
  endtask

  task automatic wait_pass_cnt(input string tag, input int n, input int bound);
    int i = 0;
    while (int'(pass_cnt) < n && i < bound) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_pass_reached"}, 64'(int'(pass_cnt) >= n), 64'd1);
  endtask

  task automatic wait_error(input string tag, input int bound);
    int i = 0;
    while (!error && i < bound) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_error"}, 64'(error), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic l0;
    int t0, t1, n;
    bit flag;

    vec[0] = '{24'd0, 16'hA5A5};
    vec[1] = '{24'd1, 16'hA5A4};
    vec[2] = '{24'd2, 16'hA5A7};
    vec[3] = '{24'd3, 16'hA5A6};
    vec[4] = '{24'd0, 16'h5A5A};
    vec[5] = '{24'd1, 16'h5A5B};
    vec[6] = '{24'd2, 16'h5A58};
    vec[7] = '{24'd3, 16'h5A59};

    // Reset state and idle hold while init_done is low
    @(negedge clk);
    check_reset_outputs("reset");
    apply_reset();
    flag = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_req !== 1'b0) flag = 1;
    end
    check("idle_no_req", 64'(flag), 64'd0);

    init_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_req && n < 2);
    check("first_req", 64'(bus.cmd_req), 64'd1);
    check("first_addr", 64'(bus.cmd_addr), 64'd0);
    check("first_we", 64'(bus.cmd_we), 64'd1);

    // Ideal responder: first pass completes cleanly
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pass1_done", 64'(done), 64'd1);
    check("pass1_cnt", 64'(pass_cnt), 64'd1);
    check("pass1_error", 64'(error), 64'd0);

    // Heartbeat half-period
    l0 = led_0;
    n = 0;
    while (led_0 == l0 && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    l0 = led_0;
    n = 0;
    while (led_0 == l0 && n < 20) begin @(negedge clk); n++; end
    t1 = cyc;
    check("blink_period", 64'(t1 - t0), 64'd8);

    wait_pass_cnt("pass2", 2, 200);
    check_writes("ideal", 0, 8);
    check("pass2_done", 64'(done), 64'd1);

    // Readback corruption at address 2
    apply_reset();
    corrupt_en = 1;
    corrupt_addr = 24'd2;
    init_done = 1'b1;
    wait_error("corrupt", 200);
    check("corrupt_timeout", 64'(timeout), 64'd0);
    check("corrupt_err_addr", 64'(err_addr), 64'd2);
    check("corrupt_led_1", 64'(led_1), 64'd1);
    check("corrupt_done", 64'(done), 64'd0);
    l0 = led_0;
    flag = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_req !== 1'b0) flag = 1;
    end
    check("corrupt_req_quiet", 64'(flag), 64'd0);
    check("corrupt_led0_frozen", 64'(led_0), 64'(l0));

    // Read data withheld for address 1
    apply_reset();
    withhold_en = 1;
    withhold_addr = 24'd1;
    init_done = 1'b1;
    n = 0;
    while (!error && n < 200) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    check("to_error", 64'(error), 64'd1);
    check("to_timeout", 64'(timeout), 64'd1);
    check("to_err_addr", 64'(err_addr), 64'd1);
    check("to_latency", 64'(t0 - last_rd_ack_edge), 64'd16);
    check("to_led_1", 64'(led_1), 64'd1);

    // Slow controller: every ack delayed by 5 cycles
    apply_reset();
    ack_delay = 5;
    init_done = 1'b1;
    wait_pass_cnt("slow", 1, 400);
    check_writes("slow", 0, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_addr_q.size()) check("slow_rd_addr", 64'(rd_addr_q[i]), 64'(i));
      else check("slow_rd_missing", 64'(rd_addr_q.size()), 64'(i + 1));
    end
    check("slow_error", 64'(error), 64'd0);

    // Reset during a read wait of the second pass
    apply_reset();
    init_done = 1'b1;
    wait_pass_cnt("mid", 1, 200);
    n = 0;
    while (rd_ack_cnt < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_rd_ack", 64'(rd_ack_cnt >= 5), 64'd1);
    @(negedge clk);
    check("mid_in_wait", 64'(bus.cmd_req), 64'd0);
    rst = 1'b1;
    init_done = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    repeat (5) @(negedge clk);
    init_done = 1'b1;
    n = 0;
    while (wr_addr_q.size() < 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_writes("restart", 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
